mod_halver_seq: RTL and testbench

Multi-cycle modular halver: computes oData = iData · 2^(−iShift) mod iMod for odd iMod, one halving step per enabled clock. It is the inverse of the mod-doubler register chain and undoes k doublings, for example to normalise accumulated 2^k scaling. It sits beside the doubler in the same datapath and shares its iEn/iClr control style. A start/busy/done handshake brackets each operation.

---
 rtl/mod_halver_seq.sv | 183 ++++++++++++++++++
 tb/tb_mod_halver_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mod_halver_seq.sv
// mod_halver_seq: multi-cycle modular halver.
// Computes oData = iData * 2^(-iShift) mod iMod (iMod odd) with one halving
// step per enabled clock, framed by a start/busy/done handshake.
// Optional feature: define MOD_HALVER_REDUCE_EN to add a REDUCE state that
// folds iData in [iMod, 2*iMod-1] into range before halving.
module mod_halver_seq #(
    parameter int BITWIDTH = 32,
    parameter int SHIFTW   = 6
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iEn,
    input  logic                iClr,
    input  logic                iStart,
    input  logic [BITWIDTH-1:0] iData,
    input  logic [BITWIDTH-1:0] iMod,
    input  logic [SHIFTW-1:0]   iShift,
    output logic                oBusy,
    output logic                oDone,
    output logic [BITWIDTH-1:0] oData
);

`ifdef MOD_HALVER_REDUCE_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2,
        ST_REDUCE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
`endif

    state_t              state, state_nxt;
    logic [BITWIDTH-1:0] x, x_nxt;
    logic [SHIFTW-1:0]   cnt, cnt_nxt;
    logic [BITWIDTH-1:0] data_nxt;
    logic                done_nxt;

    // Datapath helpers.
    logic [BITWIDTH:0]   half_sum;
    logic [BITWIDTH-1:0] half_x;
    logic                take_reduce;
    logic                last_step;
    logic                accept;

    // One halving step: odd x gets iMod added first so the sum is even.
    // The sum is one bit wider than the operands, so it never overflows.
    assign half_sum = {1'b0, x} + (x[0] ? {1'b0, iMod} : {(BITWIDTH+1){1'b0}});
    assign half_x   = half_sum[BITWIDTH:1];

    // cnt<=1 (not ==1) so a corrupted/zero count still terminates.
    assign last_step = (cnt <= SHIFTW'(1));
    assign accept    = iEn && iStart;

`ifdef MOD_HALVER_REDUCE_EN
    logic [BITWIDTH-1:0] sub_x;
    assign sub_x       = x - iMod;
    assign take_reduce = (iData >= iMod);
`else
    assign take_reduce = 1'b0;
`endif

    assign oBusy = (state != ST_IDLE);

    // State register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; clear overrides everything, DONE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (take_reduce)
                        state_nxt = ST_REDUCE_OR_RUN();
                    else if (iShift != '0)
                        state_nxt = ST_RUN;
                    else
                        state_nxt = ST_DONE;
                end
            end
`ifdef MOD_HALVER_REDUCE_EN
            ST_REDUCE: begin
                if (iEn)
                    state_nxt = (cnt == '0) ? ST_DONE : ST_RUN;
            end
`endif
            ST_RUN: begin
                if (iEn && last_step)
                    state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (iClr)
            state_nxt = ST_IDLE;
    end

    // Next values for the working register, counter and registered outputs.
    always_comb begin
        x_nxt    = x;
        cnt_nxt  = cnt;
        data_nxt = oData;
        done_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    x_nxt   = iData;
                    cnt_nxt = iShift;
                    // k=0 without reduction completes on the start edge itself.
                    if (!take_reduce && iShift == '0) begin
                        data_nxt = iData;
                        done_nxt = 1'b1;
                    end
                end
            end
`ifdef MOD_HALVER_REDUCE_EN
            ST_REDUCE: begin
                if (iEn) begin
                    x_nxt = sub_x;
                    if (cnt == '0) begin
                        data_nxt = sub_x;
                        done_nxt = 1'b1;
                    end
                end
            end
`endif
            ST_RUN: begin
                if (iEn) begin
                    x_nxt = half_x;
                    if (cnt != '0)
                        cnt_nxt = cnt - SHIFTW'(1);
                    if (last_step) begin
                        data_nxt = half_x;
                        done_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (iClr) begin
            x_nxt    = '0;
            cnt_nxt  = '0;
            data_nxt = '0;
            done_nxt = 1'b0;
        end
    end

    // Working register, counter and registered outputs.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            x     <= '0;
            cnt   <= '0;
            oData <= '0;
            oDone <= 1'b0;
        end else begin
            x     <= x_nxt;
            cnt   <= cnt_nxt;
            oData <= data_nxt;
            oDone <= done_nxt;
        end
    end

    // Reduction target from IDLE; only reachable when the REDUCE state exists.
    function automatic state_t ST_REDUCE_OR_RUN();
`ifdef MOD_HALVER_REDUCE_EN
        return ST_REDUCE;
`else
        return ST_RUN;
`endif
    endfunction

endmodule

// File: tb/tb_mod_halver_seq.sv
// Directed bench for mod_halver_seq; reduce-path vectors run only when
// MOD_HALVER_REDUCE_EN is defined.
module tb_mod_halver_seq;
    localparam int BW = 32;
    localparam int SW = 6;

    logic          iClk = 1'b0;
    logic          iRstN, iEn, iClr, iStart;
    logic [BW-1:0] iData, iMod;
    logic [SW-1:0] iShift;
    logic          oBusy, oDone;
    logic [BW-1:0] oData;

    int total = 0;
    int bad   = 0;

    mod_halver_seq #(.BITWIDTH(BW), .SHIFTW(SW)) dut (
        .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iStart(iStart),
        .iData(iData), .iMod(iMod), .iShift(iShift),
        .oBusy(oBusy), .oDone(oDone), .oData(oData)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Drive a start and clock it in (edge 0).
    task automatic start_op(input logic [BW-1:0] d, input logic [BW-1:0] m, input logic [SW-1:0] k);
        iData = d; iMod = m; iShift = k; iStart = 1'b1; iEn = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    // Count further edges until oDone, bounded.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!oDone && edges < 200) begin
            tick();
            edges++;
        end
    endtask

    // Full operation: latency and result, then the pulse must drop.
    task automatic op(input string tag, input logic [BW-1:0] d, input logic [BW-1:0] m,
                      input logic [SW-1:0] k, input int lat, input logic [BW-1:0] exp);
        int e;
        start_op(d, m, k);
        wait_done(e);
        chk({tag, "_lat"}, e, lat);
        chk({tag, "_data"}, oData, exp);
        tick();
        chk({tag, "_done_drop"}, oDone, 0);
        chk({tag, "_held"}, oData, exp);
    endtask

    initial begin
        int e;
        int seen_done;
        logic [BW-1:0] x, dbl;

        iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iStart = 1'b0;
        iData = '0; iMod = 32'd23; iShift = '0;
        repeat (2) tick();
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_data", oData, 0);
        iRstN = 1'b1;
        iEn = 1'b1;
        tick();

        // Basic halving: 5/2 mod 23 = 14; 5/8 mod 23 = 15.
        op("k1", 32'd5, 32'd23, 6'd1, 1, 32'd14);
        start_op(32'd5, 32'd23, 6'd3);
        chk("k3_busy_e0", oBusy, 1);
        chk("k3_done_e0", oDone, 0);
        wait_done(e);
        chk("k3_lat", e, 3);
        chk("k3_data", oData, 15);
        chk("k3_busy_done", oBusy, 1);
        tick();
        chk("k3_busy_fall", oBusy, 0);

        // k=0 passes data through on the start edge; a start during DONE is
        // ignored, the same start held into IDLE is accepted.
        start_op(32'd9, 32'd23, 6'd0);
        chk("k0_done", oDone, 1);
        chk("k0_data", oData, 9);
        iData = 32'd5; iShift = 6'd1; iStart = 1'b1;
        tick();
        chk("dn_start_ign_busy", oBusy, 0);
        chk("dn_start_ign_data", oData, 9);
        tick();
        iStart = 1'b0;
        chk("restart_busy", oBusy, 1);
        tick();
        chk("restart_done", oDone, 1);
        chk("restart_data", oData, 14);
        tick();

        // Stall two cycles mid-RUN: done after edge 5.
        start_op(32'd5, 32'd23, 6'd3);
        tick();
        iEn = 1'b0;
        tick();
        chk("stall_busy1", oBusy, 1);
        chk("stall_done1", oDone, 0);
        tick();
        chk("stall_busy2", oBusy, 1);
        chk("stall_data", oData, 14);
        iEn = 1'b1;
        wait_done(e);
        chk("stall_lat", 3 + e, 5);
        chk("stall_res", oData, 15);
        // DONE returns to IDLE even with iEn low.
        iEn = 1'b0;
        tick();
        chk("done_noen_busy", oBusy, 0);
        chk("done_noen_done", oDone, 0);
        iEn = 1'b1;

        // Clear at edge 2 of a k=5 run aborts with no done pulse.
        start_op(32'd1, 32'd23, 6'd5);
        tick();
        iClr = 1'b1;
        tick();
        iClr = 1'b0;
        chk("clr_data", oData, 0);
        chk("clr_busy", oBusy, 0);
        seen_done = 0;
        repeat (8) begin
            if (oDone) seen_done++;
            tick();
        end
        chk("clr_no_done", seen_done, 0);

        // Asynchronous reset mid-run.
        op("pre_rst", 32'd5, 32'd23, 6'd1, 1, 32'd14);
        start_op(32'd5, 32'd23, 6'd3);
        tick();
        #2;
        iRstN = 1'b0;
        #1;
        chk("arst_busy", oBusy, 0);
        chk("arst_data", oData, 0);
        chk("arst_done", oDone, 0);
        tick();
        iRstN = 1'b1;
        tick();

        // Boundaries: maximum k (2^-63 = 2^3 mod 23 since ord(2)=11), and a
        // full-width modulus where x+iMod needs the carry bit.
        op("kmax", 32'd1, 32'd23, 6'd63, 63, 32'd8);
        op("wide", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 6'd1, 1, 32'hFFFF_FFFE);

        // Round trip: double mod 23 in the bench, halve once in the DUT.
        for (int i = 0; i < 100; i++) begin
            x   = 32'($urandom_range(0, 22));
            dbl = (x * 2) % 23;
            start_op(dbl, 32'd23, 6'd1);
            wait_done(e);
            chk("roundtrip", oData, x);
            tick();
        end

`ifdef MOD_HALVER_REDUCE_EN
        // 30 -> 7 -> 15; 7 needs no reduction.
        op("red_k1", 32'd30, 32'd23, 6'd1, 2, 32'd15);
        op("nored_k1", 32'd7, 32'd23, 6'd1, 1, 32'd15);
        op("red_k0", 32'd30, 32'd23, 6'd0, 1, 32'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
